// File: rtl/uart_tx_device.sv
// uart_tx_device: bus-mapped 8N1 serial transmitter with a one-byte holding register
module uart_tx_device #(
  parameter int BITS = 32,
  parameter logic [BITS-1:0] BASE = 32'hF0000020,
  parameter int BAUD_DIV = 434,
  parameter int READYBIT = 0,
  parameter int BUSYBIT = 1,
  parameter int OVERRUNBIT = 2,
  parameter int IEBIT = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [BITS-1:0] ABUS,
  inout  logic [BITS-1:0] DBUS,
  input  logic            WE,
  input  logic            FLUSH,
  output logic            TXD,
  output logic            IRQ,
  output logic [11:0]     DEBUG
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [BITS-1:0] CTRL = BASE + BITS'(32'h100);
  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
  state_t state;
  logic ready, busy, ov, ie, sel_d, sel_c, baud_end;
  logic [7:0] hold, shift;
  logic [15:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [BITS-1:0] ctrl;
  assign sel_d = (ABUS == BASE) && !FLUSH;
  assign sel_c = (ABUS == CTRL) && !FLUSH;
  assign baud_end = baud_cnt == LAST;
  assign busy = state != IDLE;
  assign IRQ = ie && ready;
  assign DEBUG = {hold, ie, ov, busy, ready};
  assign DBUS = (!WE && sel_d) ? {{(BITS-8){1'b0}}, hold} : (!WE && sel_c) ? ctrl : 'z;
  // control register image for bus reads
  always_comb begin
    ctrl = '0;
    ctrl[IEBIT] = ie;
    ctrl[OVERRUNBIT] = ov;
    ctrl[BUSYBIT] = busy;
    ctrl[READYBIT] = ready;
  end
  // bus register writes and the transmit state machine; a write and a hold-to-shifter transfer never coincide since they need opposite READY
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      TXD <= 1'b1;
      ready <= 1'b1;
      ov <= 1'b0;
      ie <= 1'b0;
      hold <= '0;
      shift <= '0;
      baud_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (WE && sel_d) begin
        if (ready) begin
          hold <= DBUS[7:0];
          ready <= 1'b0;
        end else ov <= 1'b1;
      end
      if (WE && sel_c) begin
        ie <= DBUS[IEBIT];
        if (!DBUS[OVERRUNBIT]) ov <= 1'b0;
      end
      case (state)
        IDLE: begin
          TXD <= 1'b1;
          if (!ready) begin
            shift <= hold;
            ready <= 1'b1;
            baud_cnt <= '0;
            TXD <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt <= '0;
            TXD <= shift[0];
            state <= DATA;
          end else baud_cnt <= baud_cnt + 16'd1;
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shift <= shift >> 1;
            if (bit_cnt == 3'd7) begin
              TXD <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              TXD <= shift[1];
            end
          end else baud_cnt <= baud_cnt + 16'd1;
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (!ready) begin
              shift <= hold;
              ready <= 1'b1;
              TXD <= 1'b0;
              state <= START;
            end else state <= IDLE;
          end else baud_cnt <= baud_cnt + 16'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_device.sv
// tb_uart_tx_device: directed and random bus traffic checked against a frame-timeline model
module tb_uart_tx_device;
  localparam logic [31:0] BASE = 32'hF0000020;
  localparam logic [31:0] CTRL = BASE + 32'h100;
  localparam int DIV = 4;
  logic clk = 0, rst = 1, we = 0, flush = 0, den = 0;
  logic [31:0] abus = 0, drv = 0;
  wire [31:0] dbus;
  logic txd, irq;
  logic [11:0] debug;
  assign dbus = den ? drv : 'z;
  always #5 clk = ~clk;
  uart_tx_device #(.BITS(32), .BASE(BASE), .BAUD_DIV(DIV)) dut (
    .CLK(clk), .RESET(rst), .ABUS(abus), .DBUS(dbus), .WE(we),
    .FLUSH(flush), .TXD(txd), .IRQ(irq), .DEBUG(debug)
  );
  int n_assert = 0, n_fail = 0, e = 0;
  int fw[$], fs[$];
  logic [7:0] fb[$];
  logic [7:0] m_hold;
  logic m_ie, m_ov;
  // each accepted byte is a frame: written at edge fw, line goes low after edge fs, lasts 10*DIV edges
  function automatic logic m_ready();
    logic r = 1'b1;
    foreach (fw[i]) if (fw[i] <= e && e < fs[i]) r = 1'b0;
    return r;
  endfunction
  function automatic logic m_busy();
    logic b = 1'b0;
    foreach (fs[i]) if (fs[i] <= e && e < fs[i] + 10 * DIV) b = 1'b1;
    return b;
  endfunction
  function automatic logic m_txd();
    logic t = 1'b1;
    int k;
    foreach (fs[i]) begin
      if (fs[i] <= e && e < fs[i] + 10 * DIV) begin
        k = (e - fs[i]) / DIV;
        t = (k == 0) ? 1'b0 : (k <= 8) ? fb[i][k-1] : 1'b1;
      end
    end
    return t;
  endfunction
  function automatic logic [31:0] m_ctrl();
    return (32'(m_ie) << 8) | (32'(m_ov) << 2) | (32'(m_busy()) << 1) | 32'(m_ready());
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, e);
    end
  endtask
  task automatic step();
    int ne = e + 1;
    int s;
    if (rst) begin
      fw.delete(); fs.delete(); fb.delete();
      m_hold = 0; m_ie = 0; m_ov = 0;
    end else begin
      if (we && !flush && abus == BASE) begin
        if (fs.size() == 0 || fs[fs.size()-1] < ne) begin
          s = ne + 1;
          if (fs.size() != 0 && fs[fs.size()-1] + 10 * DIV > s) s = fs[fs.size()-1] + 10 * DIV;
          fw.push_back(ne); fs.push_back(s); fb.push_back(drv[7:0]);
          m_hold = drv[7:0];
        end else m_ov = 1;
      end
      if (we && !flush && abus == CTRL) begin
        m_ie = drv[8];
        if (!drv[2]) m_ov = 0;
      end
    end
    @(posedge clk);
    e = ne;
    #1;
    chk("txd", 32'(txd), 32'(m_txd()));
    chk("debug", 32'(debug), {20'b0, m_hold, m_ie, m_ov, m_busy(), m_ready()});
    chk("irq", 32'(irq), 32'(m_ie & m_ready()));
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic fl);
    we = 1; abus = a; drv = d; den = 1; flush = fl;
    step();
    we = 0; den = 0; flush = 0; abus = 0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic fl);
    logic [31:0] exp;
    we = 0; den = 0; abus = a; flush = fl;
    #1;
    exp = fl ? 32'hzzzzzzzz : (a == BASE) ? {24'b0, m_hold} : (a == CTRL) ? m_ctrl() : 32'hzzzzzzzz;
    chk(tag, dbus, exp);
    abus = 0; flush = 0;
  endtask
  initial begin
    int r;
    rst = 1; run(2); rst = 0;
    rd("reset_ctrl", CTRL, 0);
    rd("reset_data", BASE, 0);
    wr(BASE, 32'hA5, 0);
    run(45);
    rd("a5_data", BASE, 0);
    wr(BASE, 32'h55, 0);
    run(10);
    wr(BASE, 32'h0F, 0);
    run(90);
    wr(BASE, 32'h11, 0); wr(BASE, 32'h22, 0); wr(BASE, 32'h33, 0);
    run(3);
    rd("ovr_set", CTRL, 0);
    wr(CTRL, 32'h0, 0);
    rd("ovr_clr", CTRL, 0);
    wr(BASE, 32'h44, 0);
    rd("ovr_again", CTRL, 0);
    wr(CTRL, 32'h4, 0);
    rd("ovr_keep", CTRL, 0);
    run(130);
    wr(CTRL, 32'h100, 0);
    rd("ie_ctrl", CTRL, 0);
    wr(BASE, 32'h3C, 0);
    wr(BASE, 32'hC3, 0);
    run(10);
    rd("ie_busy", CTRL, 0);
    run(75);
    wr(CTRL, 32'h0, 0);
    wr(BASE, 32'h99, 1);
    run(5);
    rd("flush_ctrl", CTRL, 0);
    rd("flush_rd_data", BASE, 1);
    rd("flush_rd_ctrl", CTRL, 1);
    rd("unmapped", BASE + 32'h4, 0);
    wr(BASE, 32'h7E, 0);
    run(10);
    rst = 1; step(); rst = 0;
    rd("midreset_ctrl", CTRL, 0);
    run(3);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20) wr(BASE, $urandom(), ($urandom_range(0, 7) == 0));
      else if (r < 27) wr(CTRL, $urandom(), ($urandom_range(0, 7) == 0));
      else if (r < 40) begin
        r = $urandom_range(0, 2);
        rd("rand_rd", (r == 0) ? BASE : (r == 1) ? CTRL : BASE + 32'h8, ($urandom_range(0, 5) == 0));
        step();
      end else if (r < 41) begin
        rst = 1; step(); rst = 0;
      end else step();
    end
    run(100);
    rd("final_ctrl", CTRL, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
